// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back unit.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_W    = 2'b00,
        LD_H    = 2'b01,
        LD_B    = 2'b10,
        LD_RSVD = 2'b11
    } ld_size_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending multiply/divide result FIFO with per-entry valid bits and a
// parallel destination-match invalidate port.
module wb_pend_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_dest,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_dest,
    output logic              full,
    output logic              empty,
    output logic              head_vld,
    output logic [ADDR_W-1:0] head_dest,
    output logic [DATA_W-1:0] head_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            // A younger pipeline write kills every pending result to the same register.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (inv_en && (dest_q[i] == inv_dest)) begin
                    vld_q[i] <= 1'b0;
                end
            end
            if (do_push) begin
                dest_q[wr_ptr_q] <= push_dest;
                data_q[wr_ptr_q] <= push_data;
                vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign head_vld  = vld_q[rd_ptr_q] && !empty_q;
    assign head_dest = dest_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-back: selects ALU/load/link values and merges late
// multiply/divide results onto the single write port.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_uns,
    input  logic [DATA_W-1:0] in_pc8,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_dest,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              wb_stall,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] write_data
);

    logic              fifo_full, fifo_empty, head_vld;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic              pipe_acc, md_acc, fifo_push, fifo_pop;
    logic [1:0]        ld_off;
    logic [DATA_W-1:0] ld_byte_sh, ld_half_sh, ld_val, pipe_val;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              reg_wr_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] write_data_q;

    // Little-endian load extraction and write-back value select.
    always_comb begin
        ld_off     = in_alu[1:0];
        ld_byte_sh = in_mem >> {ld_off, 3'b000};
        ld_half_sh = in_mem >> {ld_off[1], 4'b0000};
        case (in_ld_size)
            LD_B:    ld_val = in_ld_uns ? {{(DATA_W-8){1'b0}}, ld_byte_sh[7:0]}
                                        : {{(DATA_W-8){ld_byte_sh[7]}}, ld_byte_sh[7:0]};
            LD_H:    ld_val = in_ld_uns ? {{(DATA_W-16){1'b0}}, ld_half_sh[15:0]}
                                        : {{(DATA_W-16){ld_half_sh[15]}}, ld_half_sh[15:0]};
            default: ld_val = in_mem;
        endcase
        case (in_sel)
            WB_LOAD: pipe_val = ld_val;
            WB_LINK: pipe_val = in_pc8;
            default: pipe_val = in_alu;
        endcase
    end

    // One write per cycle: stalled FIFO head, then pipeline, then FIFO head.
    always_comb begin
        pipe_acc  = in_valid && !fifo_full;
        md_acc    = md_valid && !fifo_full;
        fifo_pop  = 1'b0;
        wr_d      = 1'b0;
        addr_d    = head_dest;
        data_d    = head_data;
        if (fifo_full) begin
            fifo_pop = 1'b1;
            wr_d     = head_vld;
        end else if (pipe_acc) begin
            wr_d   = 1'b1;
            addr_d = in_dest;
            data_d = pipe_val;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            wr_d     = head_vld;
        end
        wr_d      = wr_d && (addr_d != '0);
        fifo_push = md_acc && (md_dest != '0) && !(pipe_acc && (md_dest == in_dest));
    end

    wb_pend_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (fifo_push),
        .push_dest (md_dest),
        .push_data (md_data),
        .pop       (fifo_pop),
        .inv_en    (pipe_acc),
        .inv_dest  (in_dest),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_vld  (head_vld),
        .head_dest (head_dest),
        .head_data (head_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_wr_q     <= 1'b0;
            w_addr_q     <= '0;
            write_data_q <= '0;
        end else begin
            reg_wr_q     <= wr_d;
            w_addr_q     <= addr_d;
            write_data_q <= data_d;
        end
    end

    assign reg_wr     = reg_wr_q;
    assign w_addr     = w_addr_q;
    assign write_data = write_data_q;
    assign md_ready   = !fifo_full;
    assign wb_stall   = fifo_full;

endmodule
